// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with a two-flop input synchronizer,
// a receive buffer and rda / framing_err / overrun status for the processor bus.
module spart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  output logic [7:0] data_received,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_r, state_nxt_s;
  logic       rxd_meta_r, rxd_sync_r, rxd_s;
  logic [3:0] tick_r, tick_nxt_s;
  logic [2:0] bit_r, bit_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic       good_stop_s, bad_stop_s, rd_clr_s;

  assign rxd_s    = rxd_sync_r;
  assign rd_clr_s = iocs && iorw && (ioaddr == 2'b00);

  // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // Frame state, tick/bit counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      tick_r  <= 4'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      tick_r  <= tick_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic; everything holds on cycles without an enable tick.
  always_comb begin
    state_nxt_s = state_r;
    tick_nxt_s  = tick_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    good_stop_s = 1'b0;
    bad_stop_s  = 1'b0;
    if (enable) begin
      case (state_r)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt_s = START;
            tick_nxt_s  = 4'd0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          // Eighth tick lands mid start bit: a high line here was only a glitch.
          if (tick_r == 4'd7) begin
            tick_nxt_s  = 4'd0;
            bit_nxt_s   = 3'd0;
            state_nxt_s = rxd_s ? IDLE : DATA;
          end else begin
            tick_nxt_s = tick_r + 4'd1;
          end
        end
        DATA: begin
          tick_nxt_s = tick_r + 4'd1;
          if (tick_r == 4'd15) begin
            shift_nxt_s = {rxd_s, shift_r[7:1]};
            bit_nxt_s   = bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_nxt_s = STOP;
              tick_nxt_s  = 4'd0;
            end else begin
              state_nxt_s = DATA;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end
        STOP: begin
          if (tick_r == 4'd15) begin
            good_stop_s = rxd_s;
            bad_stop_s  = !rxd_s;
            state_nxt_s = IDLE;
            tick_nxt_s  = 4'd0;
          end else begin
            tick_nxt_s = tick_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          tick_nxt_s  = 4'd0;
          bit_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Receive buffer and status flags; a completing good frame wins over a clearing read.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_received <= 8'h00;
      rda           <= 1'b0;
      framing_err   <= 1'b0;
      overrun       <= 1'b0;
    end else if (good_stop_s) begin
      data_received <= shift_r;
      rda           <= 1'b1;
      framing_err   <= 1'b0;
      overrun       <= rd_clr_s ? 1'b0 : (rda ? 1'b1 : overrun);
    end else if (bad_stop_s) begin
      framing_err <= 1'b1;
      if (rd_clr_s) begin
        rda     <= 1'b0;
        overrun <= 1'b0;
      end
    end else if (rd_clr_s) begin
      rda     <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Randomized scoreboard bench for spart_rx: stimulus pushes expected status snapshots,
// a monitor compares them one clock after the event that produces them.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rxd = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] data_received;
  logic       rda, framing_err, overrun;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       o;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         next_id = 0;
  int         div = 4;
  logic       done = 1'b0;

  // reference model of the visible receiver state
  logic [7:0] m_data;
  logic       m_rda, m_fe, m_ov;

  spart_rx dut (
    .clk(clk), .rst(rst), .enable(enable), .rxd(rxd),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .data_received(data_received), .rda(rda),
    .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(64'd5000000);
    $display("FAIL watchdog: time limit reached, got no end of stimulus, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (item %0d): got %0h, required %0h", name, id, act, exp);
    end
  endtask

  // Monitor: compares each expected snapshot in the cycle it falls due.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        mon_e = q.pop_front();
        if (mon_e.due < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL late_check (item %0d): due cycle %0d, now %0d", mon_e.id, mon_e.due, cyc);
        end else begin
          chk("data_received", mon_e.id, data_received, mon_e.d);
          chk("rda", mon_e.id, {7'd0, rda}, {7'd0, mon_e.r});
          chk("framing_err", mon_e.id, {7'd0, framing_err}, {7'd0, mon_e.f});
          chk("overrun", mon_e.id, {7'd0, overrun}, {7'd0, mon_e.o});
        end
      end
      if (done && q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL leftover: %0d expectations never checked, required 0", q.size());
        q.delete();
      end
    end
  end

  task automatic push_exp();
    exp_t e;
    e.due = cyc + 1;
    e.id  = next_id;
    e.d   = m_data;
    e.r   = m_rda;
    e.f   = m_fe;
    e.o   = m_ov;
    next_id++;
    q.push_back(e);
  endtask

  function automatic logic is_clear(input logic cs, input logic rw, input logic [1:0] addr);
    return cs && rw && (addr == 2'b00);
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic sb, input logic clr);
    if (sb) begin
      m_ov   = clr ? 1'b0 : (m_rda ? 1'b1 : m_ov);
      m_data = b;
      m_rda  = 1'b1;
      m_fe   = 1'b0;
    end else begin
      m_fe = 1'b1;
      if (clr) begin
        m_rda = 1'b0;
        m_ov  = 1'b0;
      end
    end
  endtask

  // Line level during tick t of a 160-tick frame (start, 8 data LSB first, stop).
  function automatic logic frame_bit(input logic [7:0] b, input logic sb, input int t);
    if (t < 16) return 1'b0;
    else if (t < 144) return b[(t - 16) / 16];
    else return sb;
  endfunction

  task automatic tick(input logic v, input logic acc, input logic cs, input logic rw, input logic [1:0] addr);
    rxd    = v;
    enable = 1'b1;
    if (acc) begin
      iocs   = cs;
      iorw   = rw;
      ioaddr = addr;
    end
    @(negedge clk);
    enable = 1'b0;
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;
    repeat (div - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  // Line edges are seen one tick late through the synchronizer, so the stop bit
  // is sampled on tick 153 (detect at 1, mid start at 9, data at 25+16k).
  task automatic send_frame(input logic [7:0] b, input logic sb, input logic acc,
                            input logic cs, input logic rw, input logic [1:0] addr);
    for (int t = 0; t < 160; t++) begin
      if (t == 153) begin
        model_frame(b, sb, acc && is_clear(cs, rw, addr));
        push_exp();
      end
      tick(frame_bit(b, sb, t), acc && (t == 153), cs, rw, addr);
    end
  endtask

  task automatic bus_access(input logic cs, input logic rw, input logic [1:0] addr);
    iocs   = cs;
    iorw   = rw;
    ioaddr = addr;
    if (is_clear(cs, rw, addr)) begin
      m_rda = 1'b0;
      m_ov  = 1'b0;
    end
    push_exp();
    @(negedge clk);
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;
  endtask

  task automatic do_reset();
    rxd    = 1'b1;
    rst    = 1'b1;
    m_data = 8'h00;
    m_rda  = 1'b0;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    push_exp();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       sb, acc, cs, rw;
    logic [1:0] addr;
    div = $urandom_range(2, 5);
    @(negedge clk);
    do_reset();
    idle(4);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(4);
    bus_access(1'b1, 1'b1, 2'b00);
    idle(2);

    // short low glitch: false start, nothing changes
    for (int t = 0; t < 4; t++) tick(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(30);
    push_exp();
    idle(2);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(4);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(3);
    bus_access(1'b1, 1'b1, 2'b01);
    bus_access(1'b1, 1'b0, 2'b00);
    bus_access(1'b0, 1'b1, 2'b00);
    idle(3);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(3);
    bus_access(1'b1, 1'b1, 2'b00);
    idle(3);

    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(3);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    idle(3);

    // 160-tick break
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(3);

    // reset in the middle of data bit 4
    b = 8'($urandom);
    for (int t = 0; t < 88; t++) tick(frame_bit(b, 1'b1, t), 1'b0, 1'b0, 1'b0, 2'b00);
    do_reset();
    idle(5);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    idle(4);

    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      sb   = ($urandom_range(0, 3) != 0);
      acc  = ($urandom_range(0, 2) == 0);
      cs   = ($urandom_range(0, 4) != 0);
      rw   = ($urandom_range(0, 4) != 0);
      addr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      send_frame(b, sb, acc, cs, rw, addr);
      idle($urandom_range(3, 8));
      if ($urandom_range(0, 1) == 1) begin
        cs   = ($urandom_range(0, 3) != 0);
        rw   = ($urandom_range(0, 3) != 0);
        addr = 2'($urandom_range(0, 3));
        bus_access(cs, rw, addr);
        idle(1);
      end
    end

    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
